riscv_rf_wport_arb: RTL
=======================

// Module: riscv_rf_wport_arb
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and one
//  out-of-band late-result source (multi-cycle divider / late load return). Late results
//  wait in a small queue; WB has priority, bounded by a starvation limit that stalls WB.
//  Drives the registered RF write port and flags operand hazards against queued results.
// PARAMETERS
//  MXLEN       32  data width
//  QDEPTH      2   late-result queue entries (power of 2, >=2)
//  STARVE_MAX  4   cycles a queue head may lose to WB before WB is stalled (>=1)
// PORTS
//  clk_i       in   1      clock
//  rst_ni      in   1      reset, asynchronous, active-low
//  wb_we_i     in   1      WB stage write request (held stable while wb_stall_o=1)
//  wb_dst_i    in   5      WB destination register
//  wb_r_i      in   MXLEN  WB result
//  wb_stall_o  out  1      WB write not taken this cycle; pipeline must hold WB
//  lr_req_i    in   1      late-result valid
//  lr_dst_i    in   5      late-result destination register
//  lr_r_i      in   MXLEN  late-result data
//  lr_ack_o    out  1      late result accepted this cycle (req&ack = transfer)
//  src1_i      in   5      ID-stage rs1 for hazard check
//  src2_i      in   5      ID-stage rs2 for hazard check
//  hazard_o    out  1      rs1/rs2 (non-zero) matches a valid queue entry or rf_dst_o while rf_we_o=1
//  rf_we_o     out  1      RF write enable (registered)
//  rf_dst_o    out  5      RF write address (registered)
//  rf_r_o      out  MXLEN  RF write data (registered)
// BEHAVIOUR
//  - Reset: queue empty, age counter 0, rf_we_o=0, rf_dst_o=0, rf_r_o=0; wb_stall_o=0,
//    lr_ack_o=1, hazard_o=0 (combinational from reset state). Reset mid-operation drops
//    all queued results; no RF write is issued for them.
//  - lr_ack_o = queue not full (comb). Accepted entry enters the queue tail the same edge.
//    Entries with lr_dst_i=0 are acked but discarded.
//  - Grant, evaluated each cycle (comb), result registered into rf_* next edge (latency 1):
//    1) age==STARVE_MAX and queue non-empty: grant queue head; wb_stall_o=wb_we_i.
//    2) else wb_we_i=1: grant WB; wb_stall_o=0; age++ if queue non-empty (saturating).
//    3) else queue non-empty: grant queue head.
//    4) else rf_we_o<=0 next edge.
//  - age resets to 0 whenever the queue head is dequeued or the queue is empty.
//  - WB write to x0 is granted but produces rf_we_o=0 (port slot still consumed).
//  - WAW: a granted WB write to dst X invalidates every valid queue entry with dst X
//    (younger in-order write wins); invalidated entries are dropped from the queue
//    without an RF write, freeing their slots the same edge.
//  - An lr transfer coinciding with a granted WB write to the same dst is enqueued
//    (late result is the younger value); it is not invalidated by that WB write.
//  - Simultaneous enqueue and dequeue: allowed when not full; count unchanged.
//  - Full queue: lr_ack_o=0; source must hold lr_* until acked.
//  - rf_dst_o/rf_r_o hold their last value when rf_we_o=0.
// CONFIGURATION
//  RV_WPORT_LR_BYPASS_EN defined: if queue empty, wb_we_i=0 and lr transfer with dst!=0,
//   the late result is written straight into rf_* at that edge (1-cycle latency), not
//   enqueued. Not defined: every late result is enqueued first (min 2-cycle latency).
// TESTING
//  1. Reset mid-queue: 2 entries queued, pulse rst_ni -> rf_we_o=0, lr_ack_o=1, no RF
//     writes for dropped entries after release.
//  2. Idle port: lr x5=0x1234 -> rf_we_o=1, rf_dst_o=5, rf_r_o=0x1234 after 2 edges
//     (1 edge with RV_WPORT_LR_BYPASS_EN); hazard_o=1 for src1_i=5 until written.
//  3. Starvation: continuous wb_we_i, one lr x7 queued -> WB granted 4 cycles, then
//     wb_stall_o=1 one cycle, x7 written, WB value written next cycle unchanged.
//  4. Full queue: 2 entries queued under continuous WB -> lr_ack_o=0 for third request
//     until the head drains; third accepted next cycle, order preserved.
//  5. WAW: queue holds x9=0xAA, WB writes x9=0xBB -> only 0xBB reaches RF; queue empties.
//  6. x0: lr x0 acked, never written; WB x0 -> rf_we_o=0, queued head still waits.

Source files
------------

// File: rtl/riscv_rf_wport_arb.sv
// riscv_rf_wport_arb: arbitrates the single RF write port between WB and a queued late-result source
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   wb_we_i, wb_dst_i, wb_r_i     in-order WB write request
//   wb_stall_o                    WB write not taken this cycle (pipeline holds WB)
//   lr_req_i, lr_dst_i, lr_r_i    late-result source (divider / late load)
//   lr_ack_o                      late result accepted (queue not full)
//   src1_i, src2_i                ID-stage operands for hazard check
//   hazard_o                      operand matches a pending queued write or the in-flight RF write
//   rf_we_o, rf_dst_o, rf_r_o     registered RF write port
//
// Configuration:
//   RV_WPORT_LR_BYPASS_EN  when defined, a late result arriving on an idle port with an
//                          empty queue is written straight to the RF port without queueing.
module riscv_rf_wport_arb #(
    parameter int MXLEN      = 32,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_dst_i,
    input  logic [MXLEN-1:0] wb_r_i,
    output logic             wb_stall_o,
    input  logic             lr_req_i,
    input  logic [4:0]       lr_dst_i,
    input  logic [MXLEN-1:0] lr_r_i,
    output logic             lr_ack_o,
    input  logic [4:0]       src1_i,
    input  logic [4:0]       src2_i,
    output logic             hazard_o,
    output logic             rf_we_o,
    output logic [4:0]       rf_dst_o,
    output logic [MXLEN-1:0] rf_r_o
);
    localparam int AW = $clog2(QDEPTH);
    localparam int GW = $clog2(STARVE_MAX + 1);
    localparam logic [GW-1:0] AGE_MAX = GW'(STARVE_MAX);

    // Queue is kept compacted: valid entries occupy indices 0..count-1, index 0 is the head.
    logic [QDEPTH-1:0] q_v, n_v;
    logic [4:0]        q_dst [QDEPTH];
    logic [4:0]        n_dst [QDEPTH];
    logic [MXLEN-1:0]  q_r   [QDEPTH];
    logic [MXLEN-1:0]  n_r   [QDEPTH];
    logic [GW-1:0]     age;
    logic [AW:0]       k;
    logic empty, full, age_hit, g_q, g_wb, byp, enq, hd_drop, s1_nz, s2_nz;

    assign empty      = ~|q_v;
    assign full       = &q_v;
    assign age_hit    = (age == AGE_MAX) && !empty;
    assign g_q        = !empty && (age_hit || !wb_we_i);
    assign g_wb       = wb_we_i && !age_hit;
    assign wb_stall_o = wb_we_i && age_hit;
    assign lr_ack_o   = !full;
`ifdef RV_WPORT_LR_BYPASS_EN
    assign byp = empty && !wb_we_i && lr_req_i && (lr_dst_i != '0);
`else
    assign byp = 1'b0;
`endif
    // x0 late results are acked but never stored
    assign enq     = lr_req_i && !full && (lr_dst_i != '0) && !byp;
    // head leaves the queue by dequeue or by WAW invalidation; either restarts its age
    assign hd_drop = q_v[0] && (g_q || (g_wb && q_dst[0] == wb_dst_i));
    assign s1_nz   = src1_i != '0;
    assign s2_nz   = src2_i != '0;

    // Next queue: surviving entries compacted in order, then the new tail appended.
    // The incoming entry is appended after invalidation so a same-cycle WB write
    // to the same register never kills the (younger) late result.
    always_comb begin
        n_v   = '0;
        n_dst = q_dst;
        n_r   = q_r;
        k     = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (q_v[i] && !(g_q && i == 0) && !(g_wb && q_dst[i] == wb_dst_i)) begin
                n_v[k[AW-1:0]]   = 1'b1;
                n_dst[k[AW-1:0]] = q_dst[i];
                n_r[k[AW-1:0]]   = q_r[i];
                k = k + (AW+1)'(1);
            end
        end
        if (enq) begin
            n_v[k[AW-1:0]]   = 1'b1;
            n_dst[k[AW-1:0]] = lr_dst_i;
            n_r[k[AW-1:0]]   = lr_r_i;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (q_v[i] && ((s1_nz && q_dst[i] == src1_i) || (s2_nz && q_dst[i] == src2_i)))
                hazard_o = 1'b1;
        end
        if (rf_we_o && ((s1_nz && rf_dst_o == src1_i) || (s2_nz && rf_dst_o == src2_i)))
            hazard_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_v <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_dst[i] <= '0;
                q_r[i]   <= '0;
            end
            age      <= '0;
            rf_we_o  <= 1'b0;
            rf_dst_o <= '0;
            rf_r_o   <= '0;
        end else begin
            q_v   <= n_v;
            q_dst <= n_dst;
            q_r   <= n_r;
            age   <= (empty || hd_drop) ? '0 :
                     (g_wb && age != AGE_MAX) ? age + GW'(1) : age;
            if (g_q) begin
                rf_we_o  <= 1'b1;
                rf_dst_o <= q_dst[0];
                rf_r_o   <= q_r[0];
            end else if (g_wb) begin
                // x0 write still consumes the slot but never reaches the RF
                rf_we_o <= wb_dst_i != '0;
                if (wb_dst_i != '0) begin
                    rf_dst_o <= wb_dst_i;
                    rf_r_o   <= wb_r_i;
                end
            end else if (byp) begin
                rf_we_o  <= 1'b1;
                rf_dst_o <= lr_dst_i;
                rf_r_o   <= lr_r_i;
            end else begin
                rf_we_o <= 1'b0;
            end
        end
    end
endmodule
